// File: rtl/fs_serial.sv
// fs_serial -- bit-serial full subtractor.
//
// Computes (a - b) mod 2^W one bit per clock, LSB first, through a single
// full-subtractor cell and a registered borrow. An operation accepted on
// edge E0 completes on edge EW, where done pulses and diff/bout update.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset, clears all state and outputs
//   start : request a new subtraction, only sampled while idle
//   a, b  : minuend / subtrahend, sampled on the accepting edge only
//   busy  : high while an operation is running
//   done  : one-cycle pulse when diff/bout are updated
//   diff  : (a - b) mod 2^W of the last completed operation
//   bout  : final borrow of the last completed operation (a < b)
module fs_serial #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Borrow out of one full-subtractor cell computing x - y - bin.
  function automatic logic borrow_f(input logic x, input logic y, input logic bin);
    return (~x & y) | (~x & bin) | (y & bin);
  endfunction

  // Difference bit of one full-subtractor cell.
  function automatic logic diff_bit_f(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  state_e        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  sd_q, sd_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;

  logic          d_s;
  logic          br_n_s;
  logic [W-1:0]  sd_shift_s;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;

    d_s    = diff_bit_f(sa_q[0], sb_q[0], br_q);
    br_n_s = borrow_f(sa_q[0], sb_q[0], br_q);
    // New result bit enters at the MSB; the oldest bit falls off the LSB.
    sd_shift_s = W'({d_s, sd_q} >> 1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sd_d  = sd_shift_s;
        br_d  = br_n_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          // Last bit: publish the fully shifted difference and final borrow.
          state_d = S_IDLE;
          diff_d  = sd_shift_s;
          bout_d  = br_n_s;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_fs_serial.sv
// Directed self-checking bench for fs_serial: a W=8 instance for the
// scenario tests and a W=4 instance for the exhaustive sweep.
module tb_fs_serial;

  logic       clk = 1'b0;
  logic       rst8, start8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       rst4, start4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  int checks = 0;
  int errors = 0;

  fs_serial #(.W(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  fs_serial #(.W(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; drive and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One W=8 operation: pulse start, wait for done, check latency and result.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_diff, input logic exp_bout,
                         input string name);
    int cyc;
    a8 = a; b8 = b; start8 = 1'b1;
    step();
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 20) begin
      step();
      cyc++;
    end
    checks++;
    if (done8 !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, cyc);
    end else begin
      checks++;
      if (cyc !== 8) begin
        errors++;
        $display("FAIL %s_latency: got %0d edges, expected 8", name, cyc);
      end
      checks++;
      if (diff8 !== exp_diff) begin
        errors++;
        $display("FAIL %s_diff: got %0d, expected %0d", name, diff8, exp_diff);
      end
      checks++;
      if (bout8 !== exp_bout) begin
        errors++;
        $display("FAIL %s_bout: got %0b, expected %0b", name, bout8, exp_bout);
      end
    end
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst4 = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; a4 = 4'd0; b4 = 4'd0;
    step();
    step();
    checks++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: got busy=%0b done=%0b diff=%0d bout=%0b, expected all 0",
               busy8, done8, diff8, bout8);
    end
    checks++;
    if ({busy4, done4, diff4, bout4} !== 7'd0) begin
      errors++;
      $display("FAIL reset4: got busy=%0b done=%0b diff=%0d bout=%0b, expected all 0",
               busy4, done4, diff4, bout4);
    end
    rst8 = 1'b0; rst4 = 1'b0;
    step();
  endtask

  // 100 - 37 with cycle-by-cycle busy/done checks.
  task automatic test_basic();
    a8 = 8'd100; b8 = 8'd37; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = 8'd0; b8 = 8'd0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy[%0d]: got busy=%0b done=%0b, expected busy=1 done=0",
                 i, busy8, done8);
      end
      if (i < 7) step();
    end
    step();
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%0b busy=%0b, expected done=1 busy=0", done8, busy8);
    end
    checks++;
    if (diff8 !== 8'd63 || bout8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got diff=%0d bout=%0b, expected 63/0", diff8, bout8);
    end
    step();
    checks++;
    if (done8 !== 1'b0 || diff8 !== 8'd63) begin
      errors++;
      $display("FAIL basic_hold: got done=%0b diff=%0d, expected done=0 diff=63", done8, diff8);
    end
  endtask

  task automatic test_patterns();
    run_op8(8'd5, 8'd9, 8'd252, 1'b1, "p_5_9");
    run_op8(8'd0, 8'd1, 8'd255, 1'b1, "p_0_1");
    run_op8(8'd0, 8'd0, 8'd0,   1'b0, "p_0_0");
    run_op8(8'd255, 8'd0, 8'd255, 1'b0, "p_255_0");
  endtask

  // A start raised mid-operation must be ignored.
  task automatic test_start_ignored();
    int dones;
    dones = 0;
    a8 = 8'd200; b8 = 8'd55; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    step();
    if (done8) dones++;
    start8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done8) begin
        dones++;
        checks++;
        if (diff8 !== 8'd145 || bout8 !== 1'b0) begin
          errors++;
          $display("FAIL ignore_result: got diff=%0d bout=%0b, expected 145/0", diff8, bout8);
        end
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_count: got %0d done pulses, expected 1", dones);
    end
  endtask

  // start held high: second operation accepted in the done cycle.
  task automatic test_back_to_back();
    int first_at, second_at, cyc;
    first_at = -1; second_at = -1; cyc = 0;
    a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;
    step();
    a8 = 8'd3; b8 = 8'd10;
    while (second_at < 0 && cyc < 40) begin
      step();
      cyc++;
      if (done8) begin
        if (first_at < 0) begin
          first_at = cyc;
          checks++;
          if (diff8 !== 8'd7 || bout8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got diff=%0d bout=%0b, expected 7/0", diff8, bout8);
          end
        end else begin
          second_at = cyc;
          start8 = 1'b0;
          checks++;
          if (diff8 !== 8'd249 || bout8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got diff=%0d bout=%0b, expected 249/1", diff8, bout8);
          end
        end
      end
    end
    start8 = 1'b0;
    checks++;
    if (first_at !== 8 || second_at !== 17) begin
      errors++;
      $display("FAIL b2b_timing: got done at %0d and %0d, expected 8 and 17", first_at, second_at);
    end
    step();
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%0b, expected 0", busy8);
    end
  endtask

  // Reset mid-operation aborts, clears outputs and beats a concurrent start.
  task automatic test_reset_abort();
    int dones;
    dones = 0;
    a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step(); step();
    rst8 = 1'b1; start8 = 1'b1;
    step();
    rst8 = 1'b0; start8 = 1'b0;
    checks++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%0b done=%0b diff=%0d bout=%0b, expected all 0",
               busy8, done8, diff8, bout8);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8 || busy8) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d busy/done cycles after abort, expected 0", dones);
    end
    run_op8(8'd50, 8'd20, 8'd30, 1'b0, "abort_rerun");
  endtask

  // W=4: all 256 pairs, back-to-back with start held high.
  task automatic test_exhaustive4();
    int cyc;
    logic [7:0] nxt;
    logic [3:0] ea, eb, ed;
    {a4, b4} = 8'd0;
    start4 = 1'b1;
    for (int p = 0; p < 256; p++) begin
      step();
      if (p < 255) begin
        nxt = 8'(p + 1);
        {a4, b4} = nxt;
      end else begin
        start4 = 1'b0;
      end
      cyc = 1;
      while (!done4 && cyc < 10) begin
        step();
        cyc++;
      end
      nxt = 8'(p);
      ea = nxt[7:4];
      eb = nxt[3:0];
      ed = ea - eb;
      checks++;
      if (done4 !== 1'b1 || cyc !== 5 || diff4 !== ed || bout4 !== (ea < eb)) begin
        errors++;
        $display("FAIL exh4 a=%0d b=%0d: got done=%0b edges=%0d diff=%0d bout=%0b, expected done=1 edges=5 diff=%0d bout=%0b",
                 ea, eb, done4, cyc, diff4, bout4, ed, (ea < eb));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fs_serial.md
# fs_serial

Bit-serial full subtractor. It computes `a - b` for W-bit operands one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It sits alongside the combinational adder cells as their inverse datapath. It is intended for area-constrained difference and compare paths where W+1 cycles of latency are acceptable.

## Interface
Parameters:
- `W`, default 8: operand and result width in bits; legal range is W ≥ 2.

Ports:
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: request a new subtraction; sampled only in IDLE.
- `a`  input  W: minuend; sampled on the accepting edge only.
- `b`  input  W: subtrahend; sampled on the accepting edge only.
- `busy`  output  1: high while an operation is in progress.
- `done`  output  1: one-cycle pulse; `diff` and `bout` are updated in this cycle.
- `diff`  output  W: `(a - b) mod 2^W` of the last completed operation.
- `bout`  output  1: final borrow of the last completed operation; 1 if and only if a < b (unsigned).

## Operation
- State machine has two states: IDLE and RUN.
- IDLE → RUN when `start` = 1. On that edge:
  - load `a` and `b` into shift registers SA and SB;
  - clear the borrow register `br` to 0;
  - clear the bit counter `cnt` to 0.
- RUN, on each edge:
  - bit cell: `d = SA[0] ^ SB[0] ^ br`;
  - next borrow: `br_n = (~SA[0] & SB[0]) | (~SA[0] & br) | (SB[0] & br)`;
  - SA and SB shift right by 1;
  - `d` shifts into the MSB of the internal difference register SD;
  - `br <= br_n`;
  - `cnt <= cnt + 1`.
- Width rules:
  - `cnt` is ceil(log2(W+1)) bits wide.
  - After W shifts, SD[0] holds the bit-0 result and SD[W-1] holds the bit-W-1 result.
  - No wrap of `cnt` occurs inside an operation.
- RUN → IDLE on the edge that processes bit W-1 (`cnt` == W-1). On that same edge:
  - `diff <= {d, SD[W-1:1]}`;
  - `bout <= br_n`;
  - `done <= 1`.
- `diff` and `bout` hold their values until the next completion or reset. Intermediate shifting never appears on the outputs.
- `busy` is 1 exactly while the state is RUN.
- `done` is 0 in every cycle other than the completion cycle.
- Boundary conditions:
  - `start` while RUN is ignored: no restart, and operands are not resampled.
  - `start` = 1 in the cycle where `done` = 1 is accepted, because the state is IDLE. RUN resumes on the next edge, giving back-to-back operations with no gap.
  - `a` and `b` may change freely after the accepting edge.
  - `rst` = 1 mid-operation aborts the operation. State goes to IDLE, and every output and internal register is cleared. No `done` is produced for the aborted operation.
  - `rst` has priority over `start` on the same edge.

## Timing
- Reset values:
  - outputs: `busy` = 0, `done` = 0, `diff` = 0, `bout` = 0;
  - internal: `br` = 0, `cnt` = 0, SA = SB = SD = 0;
  - state: IDLE.
- Let edge E0 be the edge that accepts `start`.
  - `busy` is 1 in the cycles after edges E0 through E(W-1).
  - Bits 0 through W-1 are processed on edges E1 through EW.
  - After EW: `busy` = 0, `done` = 1, and `diff`/`bout` are valid.
  - `done` falls after E(W+1) unless a new operation completes on that edge. That cannot happen for W ≥ 2.
- Latency from start to done is W edges. Throughput is one operation per W+1 cycles when `start` is held high.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- W=8, a=100, b=37, `start` pulsed one cycle:
  - `busy` is high for 8 cycles;
  - `done` pulses exactly 8 edges after the accept;
  - `diff` = 63, `bout` = 0.
- W=8, a=5, b=9: `diff` = 252, `bout` = 1. Then a=0, b=1: `diff` = 255, `bout` = 1. Then a=0, b=0: `diff` = 0, `bout` = 0.
- W=8, start a=200, b=55, then pulse `start` with a=1, b=2 on cycle 3 of RUN:
  - the second request is ignored;
  - exactly one `done` is produced, with `diff` = 145, `bout` = 0.
- W=8, hold `start` high with operands a=10, b=3 for the first operation and a=3, b=10 for the second:
  - `done` pulses every 9 cycles;
  - results are 7/0, then 249/1.
- W=8, start a=50, b=20, assert `rst` for one cycle after 4 RUN edges:
  - all outputs return to 0 and `busy` = 0;
  - no `done` is produced;
  - a subsequent start with a=50, b=20 gives `diff` = 30 and `bout` = 0.
- W=4, exhaustive check of all 256 (a, b) pairs, back-to-back: every result equals `(a - b) mod 16`, and `bout` = (a < b).
